// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter slice.
package fifo_arb_pkg;

    // Arbiter FSM: no grant held, or one requester owns the FIFO write port
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Width of an index able to address n items (never narrower than one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester handshake plus FIFO write port, shared by the arbiter and its environment.
interface fifo_write_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         fifo_input_data;
    logic                          fifo_write_enable;
    logic                          fifo_full;

    // Environment side: producers and the FIFO
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_input_data, fifo_write_enable
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_input_data, fifo_write_enable
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request at or after start, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan all N positions starting at start; the first hit wins
    always_comb begin
        found = 1'b0;
        idx   = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            int pos;
            pos = (int'(start) + k) % N;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bursts of up to BURST_MAX beats with zero-gap hand-over.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    fifo_write_arbiter_if.slave        bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int              IW        = idx_width(NUM_REQ);
    localparam int              CW        = $clog2(BURST_MAX + 1);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0]   BEAT_LAST = CW'(BURST_MAX - 1);

    state_e          state_r;
    state_e          state_nxt_s;
    logic [IW-1:0]   grant_r;
    logic [IW-1:0]   last_grant_r;
    logic [CW-1:0]   beat_cnt_r;
    logic [IW-1:0]   base_s;
    logic [IW-1:0]   start_s;
    logic            pick_found_s;
    logic [IW-1:0]   pick_idx_s;
    logic            gvalid_s;
    logic            write_s;
    logic            release_s;

    // Search origin: one past the current holder while bursting (so the holder
    // is considered last), one past the previous holder when idle
    always_comb begin
        base_s  = (state_r == BURST) ? grant_r : last_grant_r;
        start_s = (base_s == LAST_IDX) ? {IW{1'b0}} : base_s + 1'b1;
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .start (start_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Beat transfer and grant release conditions for the current holder
    always_comb begin
        gvalid_s  = bus.req_valid[grant_r];
        write_s   = 1'b0;
        release_s = 1'b0;
        if (state_r == BURST) begin
            write_s   = gvalid_s && !bus.fifo_full;
            release_s = (write_s && (beat_cnt_r == BEAT_LAST)) || !gvalid_s;
        end else begin
            write_s   = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: stay in BURST across a release when someone else is waiting
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = pick_found_s ? BURST : IDLE;
            BURST:   state_nxt_s = (release_s && !pick_found_s) ? IDLE : BURST;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant holder, priority history and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r      <= {IW{1'b0}};
            last_grant_r <= LAST_IDX;
            beat_cnt_r   <= {CW{1'b0}};
        end else if (state_r == IDLE) begin
            grant_r    <= pick_found_s ? pick_idx_s : {IW{1'b0}};
            beat_cnt_r <= {CW{1'b0}};
        end else if (release_s) begin
            last_grant_r <= grant_r;
            grant_r      <= pick_found_s ? pick_idx_s : {IW{1'b0}};
            beat_cnt_r   <= {CW{1'b0}};
        end else if (write_s) begin
            beat_cnt_r <= beat_cnt_r + 1'b1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // FSM outputs: steer the holder's data and handshake; everything quiet in reset or idle
    always_comb begin
        busy                  = 1'b0;
        grant_id              = {IW{1'b0}};
        bus.req_ready         = {NUM_REQ{1'b0}};
        bus.fifo_write_enable = 1'b0;
        bus.fifo_input_data   = {DATA_WIDTH{1'b0}};
        if (!rst && (state_r == BURST)) begin
            busy                   = 1'b1;
            grant_id               = grant_r;
            bus.req_ready[grant_r] = !bus.fifo_full;
            bus.fifo_write_enable  = write_s;
            bus.fifo_input_data    = bus.req_data[grant_r*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus a
// randomized run, all checked against a cycle model built from the grant rules.
module tb_fifo_write_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;

    fifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus();

    fifo_write_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .BURST_MAX  (BM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the port, who held it last, beats written so far
    int m_holder = -1;
    int m_last   = NR - 1;
    int m_cnt    = 0;
    int cyc      = 0;

    typedef struct {
        int         gid;
        logic [7:0] data;
        int         cyc;
    } wr_t;
    wr_t log_q[$];

    logic          obs_we;
    logic [NR-1:0] obs_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First valid requester scanning upward from start with wrap-around, -1 if none
    function automatic int pick(input int start, input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            if (v[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs mid-cycle, log writes, advance the model at the edge
    task automatic step();
        logic [NR-1:0] rdy_e;
        logic          we_e;
        bit            holding;
        bit            wrote;
        #1;
        holding = !rst && (m_holder >= 0);
        rdy_e   = '0;
        we_e    = 1'b0;
        if (holding && !bus.fifo_full) rdy_e[m_holder] = 1'b1;
        if (holding) we_e = bus.req_valid[m_holder] && !bus.fifo_full;
        chk("busy", busy, holding);
        chk("grant_id", grant_id, holding ? m_holder : 0);
        chk("req_ready", bus.req_ready, rdy_e);
        chk("write_enable", bus.fifo_write_enable, we_e);
        if (holding) chk("fifo_data", bus.fifo_input_data, bus.req_data[m_holder*DW +: DW]);
        chk("no_write_when_full", bus.fifo_write_enable && bus.fifo_full, 1'b0);
        chk("ready_at_most_one", $countones(bus.req_ready) <= 1, 1'b1);
        obs_we  = bus.fifo_write_enable;
        obs_rdy = bus.req_ready;
        if (obs_we === 1'b1) log_q.push_back('{int'(grant_id), bus.fifo_input_data, cyc});
        @(posedge clk);
        if (rst) begin
            m_holder = -1;
            m_last   = NR - 1;
            m_cnt    = 0;
        end else if (m_holder < 0) begin
            m_holder = pick((m_last + 1) % NR, bus.req_valid);
            m_cnt    = 0;
        end else begin
            wrote = bus.req_valid[m_holder] && !bus.fifo_full;
            if (wrote) m_cnt++;
            if ((wrote && m_cnt == BM) || !bus.req_valid[m_holder]) begin
                m_last   = m_holder;
                m_holder = pick((m_holder + 1) % NR, bus.req_valid);
                m_cnt    = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.fifo_full = 1'b0;
        step();
        step();
        rst = 1'b0;
        log_q.delete();
        cyc = 0;
    endtask

    task automatic chk_log(input string tag, input int j, input int gid, input int data, input int c);
        if (j < log_q.size()) begin
            chk({tag, "_gid"}, log_q[j].gid, gid);
            if (data >= 0) chk({tag, "_data"}, log_q[j].data, data);
            chk({tag, "_cycle"}, log_q[j].cyc, c);
        end else begin
            chk({tag, "_missing"}, log_q.size(), j + 1);
        end
    endtask

    initial begin
        int k;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset state and single requester re-grant with no gap
        reset_dut();
        k = 0;
        for (int i = 0; i < 9; i++) begin
            bus.req_valid = (k < 6) ? 4'b0001 : 4'b0000;
            bus.req_data  = {24'h0, 8'hA0 + 8'(k)};
            step();
            if (obs_we === 1'b1) k++;
        end
        chk("t1_writes", log_q.size(), 6);
        for (int j = 0; j < 6; j++) chk_log("t1", j, 0, 8'hA0 + j, j + 1);

        // All valid: order 0,1,2,3,0 with four beats each, back to back
        reset_dut();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h33323130;
        for (int i = 0; i < 21; i++) step();
        chk("t2_writes", log_q.size(), 20);
        for (int j = 0; j < 20; j++) chk_log("t2", j, (j / 4) % 4, 8'h30 + (j / 4) % 4, j + 1);
        bus.req_valid = '0;
        step();
        step();

        // FIFO full stalls requester 2 for three cycles, then the burst completes and rotates
        reset_dut();
        bus.req_data = 32'hD3D2D1D0;
        for (int s = 0; s < 10; s++) begin
            bus.req_valid = (s == 0) ? 4'b0100 : 4'b1100;
            bus.fifo_full = (s >= 3 && s <= 5);
            step();
            if (s >= 3 && s <= 5) chk("t3_ready2_while_full", obs_rdy[2], 1'b0);
        end
        bus.fifo_full = 1'b0;
        chk("t3_writes", log_q.size(), 6);
        chk_log("t3_b1", 0, 2, 8'hD2, 1);
        chk_log("t3_b2", 1, 2, 8'hD2, 2);
        chk_log("t3_b3", 2, 2, 8'hD2, 6);
        chk_log("t3_b4", 3, 2, 8'hD2, 7);
        chk_log("t3_rot", 4, 3, 8'hD3, 8);

        // Requester 1 drops valid after one beat; requester 3 takes over
        reset_dut();
        bus.req_data = 32'h43424140;
        for (int s = 0; s < 5; s++) begin
            bus.req_valid = (s == 0) ? 4'b0010 : (s == 1) ? 4'b1010 : 4'b1000;
            step();
        end
        chk("t4_writes", log_q.size(), 3);
        chk_log("t4_r1", 0, 1, 8'h41, 1);
        chk_log("t4_r3", 1, 3, 8'h43, 3);

        // Reset mid-burst: no further writes, priority history cleared
        reset_dut();
        bus.req_data = 32'h53525150;
        for (int s = 0; s < 6; s++) begin
            rst           = (s == 3);
            bus.req_valid = (s < 4) ? 4'b0001 : 4'b0011;
            step();
        end
        rst = 1'b0;
        chk("t5_writes", log_q.size(), 3);
        chk_log("t5_b2", 1, 0, 8'h50, 2);
        chk_log("t5_after", 2, 0, 8'h50, 5);

        // Randomized traffic, full and occasional reset against the model
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 3) == 0) bus.req_valid = 4'($urandom);
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            bus.req_data  = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each requester's data word and of the FIFO write data.
REQ-002 Parameter NUM_REQ, default 4: number of producers sharing one FIFO write port; legal range 2..16.
REQ-003 Parameter BURST_MAX, default 4: maximum write beats per grant before rotation; legal range 1..256.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester data-valid.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  packed requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both high at a clk edge.
REQ-009 fifo_input_data  output  DATA_WIDTH  data to FIFO write port.
REQ-010 fifo_write_enable  output  1  active-high FIFO write strobe.
REQ-011 fifo_full  input  1  FIFO full flag.
REQ-012 grant_id  output  $clog2(NUM_REQ)  index of the current grant holder; 0 when idle.
REQ-013 busy  output  1  high while a grant is held.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE (no grant) and BURST (one requester granted).
REQ-015 In IDLE, all req_ready and fifo_write_enable SHALL be 0.
REQ-016 In IDLE, if any req_valid is high, the next state SHALL be BURST, granting the first valid requester in round-robin order starting at last_grant+1 (mod NUM_REQ).
REQ-017 Latency from a requester's valid rising in IDLE to its first write SHALL be one cycle.
REQ-018 In BURST with grant g: req_ready[g] SHALL be !fifo_full; all other req_ready SHALL be 0.
REQ-019 In BURST with grant g: fifo_write_enable SHALL be req_valid[g] && !fifo_full, and fifo_input_data SHALL be req_data[g]. Both paths are combinational; no data is stored in this block.
REQ-020 A beat counter SHALL increment on each write beat and SHALL hold while fifo_full is high; there is no timeout on full.
REQ-021 The grant SHALL be released on the edge where either (a) a write occurs with beat count == BURST_MAX-1, or (b) req_valid[g] is low.
REQ-022 On release, last_grant SHALL become g. If any other requester is valid, the FSM SHALL stay in BURST and grant the next one round-robin after g, with a zero-cycle gap and the counter cleared. Otherwise the next state SHALL be IDLE.
REQ-023 The round-robin search after a release SHALL consider g itself last, so g is re-granted only when no other requester is valid.
REQ-024 The counter width SHALL be $clog2(BURST_MAX+1); the counter SHALL clear on every new grant.
REQ-025 fifo_write_enable SHALL never be high while fifo_full is high.
REQ-026 At most one req_ready bit SHALL be high in any cycle.

Reset
REQ-027 While rst is high at a clk edge: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), counter=0, grant=0.
REQ-028 During and after reset: req_ready=0, fifo_write_enable=0, busy=0, grant_id=0.
REQ-029 Reset mid-burst SHALL drop the grant immediately with no further writes, and SHALL NOT restore priority history.

Structure
REQ-030 The package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, BURST) and a clog2-based index-width helper constant.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, start index; outputs: found flag, index), instantiated once.
REQ-032 All sequential logic SHALL use synchronous reset on clk only.

Verification (NUM_REQ=4, BURST_MAX=4, DATA_WIDTH=8)
REQ-033 After reset, req_valid=0001 with data 0xA0..0xA5 held valid -> 4 writes 0xA0..0xA3 starting one cycle after valid, then the same requester is re-granted with no gap and writes 0xA4, 0xA5.
REQ-034 req_valid=1111 held continuously -> grant order 0,1,2,3,0, with 4 beats each and no idle cycles between grants.
REQ-035 Requester 2 is granted, fifo_full=1 for 3 cycles after 2 beats -> no write and req_ready[2]=0 for those 3 cycles; the remaining 2 beats complete after full drops; counter reaches 4 and the grant rotates.
REQ-036 Requester 1 drops valid after 1 beat while requester 3 is valid -> the grant passes to 3 on the next edge and 3 writes in the following cycle.
REQ-037 rst asserted mid-burst on requester 0 beat 2 -> no write on the following cycle; after release with req_valid=0011, requester 0 is granted first.
REQ-038 Throughout all tests, assertions check REQ-025 and REQ-026 every cycle.
